// File: rtl/morse_pkg.sv
// Shared Morse encoder definitions: symbol codes, FSM states, table widths
// and timing multipliers (in Morse units).
package morse_pkg;
  localparam logic [5:0] SPACE = 6'd0;
  localparam logic [5:0] A = 6'd1,  B = 6'd2,  C = 6'd3,  D = 6'd4,  E = 6'd5;
  localparam logic [5:0] F = 6'd6,  G = 6'd7,  H = 6'd8,  I = 6'd9,  J = 6'd10;
  localparam logic [5:0] K = 6'd11, L = 6'd12, M = 6'd13, N = 6'd14, O = 6'd15;
  localparam logic [5:0] P = 6'd16, Q = 6'd17, R = 6'd18, S = 6'd19, T = 6'd20;
  localparam logic [5:0] U = 6'd21, V = 6'd22, W = 6'd23, X = 6'd24, Y = 6'd25;
  localparam logic [5:0] Z = 6'd26;
  localparam logic [5:0] D0 = 6'd27, D1 = 6'd28, D2 = 6'd29, D3 = 6'd30, D4 = 6'd31;
  localparam logic [5:0] D5 = 6'd32, D6 = 6'd33, D7 = 6'd34, D8 = 6'd35, D9 = 6'd36;

  localparam int LEN_W = 3;
  localparam int PAT_W = 5;

  localparam int DOT_U  = 1;
  localparam int DASH_U = 3;
  localparam int GAP_U  = 1;
  localparam int CGAP_U = 3;
  localparam int WGAP_U = 4;

  typedef enum logic [2:0] {IDLE, MARK, GAP, CGAP, WGAP} state_t;
endpackage

// File: rtl/morse_lut.sv
// Code to {valid, len, pattern} table. Pattern is right-aligned, first
// element in bit len-1, 1 = dash.
module morse_lut
  import morse_pkg::*;
#(
  parameter int DIGITS_EN = 1
) (
  input  logic [5:0]       code,
  output logic             valid,
  output logic [LEN_W-1:0] len,
  output logic [PAT_W-1:0] pattern
);
  logic [LEN_W+PAT_W-1:0] ent;

  always_comb begin
    ent = '0;
    case (code)
      A:  ent = {3'd2, 5'b00001};
      B:  ent = {3'd4, 5'b01000};
      C:  ent = {3'd4, 5'b01010};
      D:  ent = {3'd3, 5'b00100};
      E:  ent = {3'd1, 5'b00000};
      F:  ent = {3'd4, 5'b00010};
      G:  ent = {3'd3, 5'b00110};
      H:  ent = {3'd4, 5'b00000};
      I:  ent = {3'd2, 5'b00000};
      J:  ent = {3'd4, 5'b00111};
      K:  ent = {3'd3, 5'b00101};
      L:  ent = {3'd4, 5'b00100};
      M:  ent = {3'd2, 5'b00011};
      N:  ent = {3'd2, 5'b00010};
      O:  ent = {3'd3, 5'b00111};
      P:  ent = {3'd4, 5'b00110};
      Q:  ent = {3'd4, 5'b01101};
      R:  ent = {3'd3, 5'b00010};
      S:  ent = {3'd3, 5'b00000};
      T:  ent = {3'd1, 5'b00001};
      U:  ent = {3'd3, 5'b00001};
      V:  ent = {3'd4, 5'b00001};
      W:  ent = {3'd3, 5'b00011};
      X:  ent = {3'd4, 5'b01001};
      Y:  ent = {3'd4, 5'b01011};
      Z:  ent = {3'd4, 5'b01100};
      D0: ent = {3'd5, 5'b11111};
      D1: ent = {3'd5, 5'b01111};
      D2: ent = {3'd5, 5'b00111};
      D3: ent = {3'd5, 5'b00011};
      D4: ent = {3'd5, 5'b00001};
      D5: ent = {3'd5, 5'b00000};
      D6: ent = {3'd5, 5'b10000};
      D7: ent = {3'd5, 5'b11000};
      D8: ent = {3'd5, 5'b11100};
      D9: ent = {3'd5, 5'b11110};
      default: ent = '0;
    endcase
    // len == 0 marks an empty slot (space or invalid code)
    valid = (ent[LEN_W+PAT_W-1 -: LEN_W] != '0) && ((DIGITS_EN != 0) || (code < D0));
  end

  assign len     = ent[LEN_W+PAT_W-1 -: LEN_W];
  assign pattern = ent[PAT_W-1:0];
endmodule

// File: rtl/morse_tx_encoder.sv
// Morse keyer: accepts one symbol code at a time and keys it out with
// standard element, character and word spacing.
module morse_tx_encoder
  import morse_pkg::*;
#(
  parameter int UNIT_TICKS = 4,
  parameter int DIGITS_EN  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sym_valid,
  input  logic [5:0] sym_code,
  output logic       sym_ready,
  output logic       key_out,
  output logic       busy,
  output logic       done,
  output logic       err
);
  localparam int CW = $clog2(4*UNIT_TICKS);
  localparam logic [CW-1:0] T_DOT  = CW'(DOT_U*UNIT_TICKS - 1);
  localparam logic [CW-1:0] T_DASH = CW'(DASH_U*UNIT_TICKS - 1);
  localparam logic [CW-1:0] T_GAP  = CW'(GAP_U*UNIT_TICKS - 1);
  localparam logic [CW-1:0] T_CGAP = CW'(CGAP_U*UNIT_TICKS - 1);
  localparam logic [CW-1:0] T_WGAP = CW'(WGAP_U*UNIT_TICKS - 1);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [LEN_W-1:0] idx, idx_nxt, len_r, len_nxt;
  logic [PAT_W-1:0] pat_r, pat_nxt;
  logic             done_nxt, err_nxt;

  logic             lut_valid;
  logic [LEN_W-1:0] lut_len, first_sel, next_sel;
  logic [PAT_W-1:0] lut_pat;

  morse_lut #(.DIGITS_EN(DIGITS_EN)) u_lut (
    .code    (sym_code),
    .valid   (lut_valid),
    .len     (lut_len),
    .pattern (lut_pat)
  );

  assign first_sel = lut_len - 3'd1;
  assign next_sel  = len_r - idx - 3'd2;
  assign sym_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    len_nxt   = len_r;
    pat_nxt   = pat_r;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      IDLE: if (sym_valid) begin
        if (sym_code == SPACE) begin
          state_nxt = WGAP;
          cnt_nxt   = T_WGAP;
        end else if (lut_valid) begin
          // the looked-up symbol is latched here; sym_code is ignored until IDLE
          state_nxt = MARK;
          idx_nxt   = '0;
          len_nxt   = lut_len;
          pat_nxt   = lut_pat;
          cnt_nxt   = lut_pat[first_sel] ? T_DASH : T_DOT;
        end else begin
          err_nxt = 1'b1;
        end
      end
      MARK: if (cnt == '0) begin
        if (idx == len_r - 3'd1) begin
          state_nxt = CGAP;
          cnt_nxt   = T_CGAP;
        end else begin
          state_nxt = GAP;
          cnt_nxt   = T_GAP;
        end
      end else cnt_nxt = cnt - 1'b1;
      GAP: if (cnt == '0) begin
        state_nxt = MARK;
        idx_nxt   = idx + 3'd1;
        cnt_nxt   = pat_r[next_sel] ? T_DASH : T_DOT;
      end else cnt_nxt = cnt - 1'b1;
      CGAP, WGAP: if (cnt == '0) begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
      end else cnt_nxt = cnt - 1'b1;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      len_r   <= '0;
      pat_r   <= '0;
      key_out <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      idx     <= idx_nxt;
      len_r   <= len_nxt;
      pat_r   <= pat_nxt;
      key_out <= (state_nxt == MARK);
      done    <= done_nxt;
      err     <= err_nxt;
    end
  end
endmodule

// File: tb/tb_morse_tx_encoder.sv
// Directed bench for morse_tx_encoder, UNIT_TICKS = 2; a second instance
// has digits disabled.
module tb_morse_tx_encoder;
  logic       clk, rst_n;
  logic       sym_valid, v0;
  logic [5:0] sym_code, c0;
  logic       sym_ready, key_out, busy, done, err;
  logic       ready0, key0, busy0, done0, err0;

  int checks = 0;
  int errors = 0;

  morse_tx_encoder #(.UNIT_TICKS(2), .DIGITS_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .sym_valid(sym_valid), .sym_code(sym_code),
    .sym_ready(sym_ready), .key_out(key_out), .busy(busy), .done(done), .err(err)
  );

  morse_tx_encoder #(.UNIT_TICKS(2), .DIGITS_EN(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .sym_valid(v0), .sym_code(c0),
    .sym_ready(ready0), .key_out(key0), .busy(busy0), .done(done0), .err(err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Present code for one accepted edge, then trace key/done/busy for n cycles.
  task automatic play(input logic [5:0] code, input int n,
                      output logic [63:0] kt, output logic [63:0] dt, output logic [63:0] bt);
    kt = '0; dt = '0; bt = '0;
    @(negedge clk);
    sym_valid = 1'b1;
    sym_code  = code;
    @(posedge clk);
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      kt = {kt[62:0], key_out};
      dt = {dt[62:0], done};
      bt = {bt[62:0], busy};
      if (i == 1) begin
        sym_valid = 1'b0;
        sym_code  = 6'd36;
      end
    end
  endtask

  task automatic play0(input logic [5:0] code, output logic [63:0] et,
                       output logic [63:0] kt, output logic [63:0] dt);
    et = '0; kt = '0; dt = '0;
    @(negedge clk);
    v0 = 1'b1;
    c0 = code;
    @(posedge clk);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      et = {et[62:0], err0};
      kt = {kt[62:0], key0};
      dt = {dt[62:0], done0};
      if (i == 1) v0 = 1'b0;
    end
  endtask

  logic [63:0] kt, dt, bt, et;
  logic        acc;

  initial begin
    rst_n = 1'b0; sym_valid = 1'b0; sym_code = '0; v0 = 1'b0; c0 = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_key",   64'(key_out),   64'd0);
    chk("rst_busy",  64'(busy),      64'd0);
    chk("rst_ready", 64'(sym_ready), 64'd1);
    chk("rst_done",  64'(done),      64'd0);
    chk("rst_err",   64'(err),       64'd0);

    // E: dot, then 6-cycle character gap, done in cycle 9
    play(6'd5, 9, kt, dt, bt);
    chk("E_key",   kt, 64'(9'b110000000));
    chk("E_done",  dt, 64'(9'b000000001));
    chk("E_busy",  bt, 64'(9'b111111110));
    chk("E_ready", 64'(sym_ready), 64'd1);

    // A: dot, gap, dash, character gap
    play(6'd1, 17, kt, dt, bt);
    chk("A_key",  kt, 64'(17'b11001111110000000));
    chk("A_done", dt, 64'(17'b1));

    // digit 0: five dashes
    play(6'd27, 45, kt, dt, bt);
    chk("D0_key",  kt, 64'({{4{8'b11111100}}, 6'b111111, 7'b0}));
    chk("D0_done", dt, 64'(45'b1));

    // invalid codes on both instances, digit on the digit-less instance
    play0(6'd40, et, kt, dt);
    chk("inv40_err",  et, 64'(3'b100));
    chk("inv40_key",  kt, 64'd0);
    chk("inv40_done", dt, 64'd0);
    chk("inv40_busy", 64'(busy0), 64'd0);
    play0(6'd28, et, kt, dt);
    chk("nodig_err",  et, 64'(3'b100));
    chk("nodig_key",  kt, 64'd0);
    chk("nodig_done", dt, 64'd0);
    chk("nodig_rdy",  64'(ready0), 64'd1);
    play(6'd40, 3, kt, dt, bt);
    chk("dut_inv_key",  kt, 64'd0);
    chk("dut_inv_done", dt, 64'd0);
    chk("dut_inv_err",  64'(err), 64'd0);

    // T then space with sym_valid held: back-to-back acceptance
    kt = '0; dt = '0;
    @(negedge clk);
    sym_valid = 1'b1;
    sym_code  = 6'd20;
    @(posedge clk);
    for (int i = 1; i <= 22; i++) begin
      @(negedge clk);
      kt = {kt[62:0], key_out};
      dt = {dt[62:0], done};
      if (i == 13) sym_code = 6'd0;
      if (i == 14) sym_valid = 1'b0;
    end
    chk("TW_key",  kt, 64'({6'b111111, 16'b0}));
    chk("TW_done", dt, 64'({12'b0, 1'b1, 8'b0, 1'b1}));

    // reset in the middle of a dash
    @(negedge clk);
    sym_valid = 1'b1;
    sym_code  = 6'd20;
    @(posedge clk);
    @(negedge clk);
    sym_valid = 1'b0;
    @(negedge clk);
    chk("mid_key_on", 64'(key_out), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_key",  64'(key_out), 64'd0);
    chk("arst_busy", 64'(busy),    64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_ready", 64'(sym_ready), 64'd1);
    chk("post_busy",  64'(busy),      64'd0);
    acc = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      acc = acc | key_out | done;
    end
    chk("no_resume", 64'(acc), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
